ps2_scan_rx: RTL

Receives PS/2 keyboard frames on the raw ps2_clk/ps2_data pins and delivers validated 8-bit scan-code bytes to the display path. The display path includes the scan-code-to-7-segment decoder, which maps 8'h1C ('A') to its glyph. Framing and odd parity are checked, the 0xF0 break prefix is optionally folded into a release flag, and a stalled frame is abandoned by watchdog. The block sits between the keyboard pins and the decoder, in the system clock domain.

---
 rtl/ps2_pkg.sv | 9 +
 rtl/ps2_sync_edge.sv | 30 +++
 rtl/ps2_scan_rx.sv | 115 +++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;
    localparam logic [7:0] BREAK_PREFIX    = 8'hF0;
    localparam int         FRAME_DATA_BITS = 8;
    function automatic int timeout_w(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: synchronises the raw PS/2 lines and flags ps2_clk falling edges.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_s,
    output logic fall_tick
);
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q, fall_q;
    // Idle-high reset values keep reset release from looking like an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
            fall_q      <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
        end
    end
    assign data_s    = data_sync_q[SYNC_STAGES-1];
    assign fall_tick = fall_q;
endmodule

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 frame receiver with odd-parity/stop checks and a stall watchdog.
// Defining PS2_BREAK_FILTER_EN folds the F0 break prefix into key_released.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       key_released,
    output logic       frame_err
);
    localparam int TIMEOUT_W = timeout_w(TIMEOUT_CYCLES);
    localparam int CNT_W     = $clog2(FRAME_DATA_BITS);
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             shift_q, shift_d, code_q, code_d;
    logic                   parity_q, parity_d, valid_q, err_q;
    logic [TIMEOUT_W-1:0]   wd_q, wd_d, wd_inc;
    logic                   data_s, fall_tick, accept, reject, report;
    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data_s    (data_s),
        .fall_tick (fall_tick)
    );
    assign wd_inc = wd_q + 1'b1;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        accept   = 1'b0;
        reject   = 1'b0;
        wd_d     = (state_q == IDLE || fall_tick) ? '0 : wd_inc;
        if (fall_tick) begin
            case (state_q)
                IDLE: if (!data_s) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
                DATA: begin
                    shift_d = {data_s, shift_q[7:1]};
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == CNT_W'(FRAME_DATA_BITS - 1)) ? PARITY : DATA;
                end
                PARITY: begin
                    parity_d = data_s;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    accept  = data_s && (^shift_q ^ parity_q);
                    reject  = !accept;
                end
            endcase
        end else if (state_q != IDLE && wd_inc == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            reject  = 1'b1;
        end
        code_d = report ? shift_q : code_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            wd_q     <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            wd_q     <= wd_d;
            code_q   <= code_d;
            valid_q  <= report;
            err_q    <= reject;
        end
    end
`ifdef PS2_BREAK_FILTER_EN
    logic brk_q, rel_q, is_brk;
    // A second F0 while one is pending is a real released-key byte
    assign is_brk = (shift_q == BREAK_PREFIX) && !brk_q;
    assign report = accept && !is_brk;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            brk_q <= 1'b0;
            rel_q <= 1'b0;
        end else if (accept) begin
            brk_q <= is_brk;
            rel_q <= is_brk ? rel_q : brk_q;
        end else if (reject) begin
            brk_q <= 1'b0;
        end
    end
    assign key_released = rel_q;
`else
    assign report       = accept;
    assign key_released = 1'b0;
`endif
    assign scan_code  = code_q;
    assign code_valid = valid_q;
    assign frame_err  = err_q;
endmodule
